// File: rtl/magic_packet_checker.sv
// ----------------------------------------------------------------------------
// magic_packet_checker
//
// Scoreboard stage that sits next to a MagicPacketTracker around a FIFO under
// verification. One pushed word is chosen as the "magic packet" and its data
// is latched. The tracker reports how many entries are queued ahead of it
// (cnt). When that count reaches zero and the FIFO pops, the head data must
// equal the latched word. The checker also raises an error if the packet
// lingers too long or if the tracker count leaves the legal range.
//
// Parameters
//   WIDTH    FIFO data width
//   DEPTH    FIFO depth (power of two, >= 2)
//   CNTWID   tracker count width
//   MAXWAIT  TRACK cycles allowed before a liveness error (>= 1)
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   push        FIFO write accepted this cycle
//   pop         FIFO read accepted this cycle
//   start       capture request
//   data_in     FIFO write data
//   data_out    FIFO head data (valid when pop=1)
//   cnt         tracker count: entries ahead of the magic packet
//   captured    to tracker: magic packet has been (or is being) captured
//   magic_data  latched magic packet data
//   state       IDLE=0, TRACK=1, DONE=2
//   exit        one-cycle pulse when the magic packet leaves the FIFO
//   err         sticky error flag
//   prop        ~err, property signal for formal tools
// ----------------------------------------------------------------------------
module magic_packet_checker #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int CNTWID  = $clog2(DEPTH) + 1,
    parameter int MAXWAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  data_out,
    input  logic [CNTWID-1:0] cnt,
    output logic              captured,
    output logic [WIDTH-1:0]  magic_data,
    output logic [1:0]        state,
    output logic              exit,
    output logic              err,
    output logic              prop
);

    localparam int WCW = $clog2(MAXWAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   magic_q;
    logic [WCW-1:0]     wait_q;
    logic               err_q;

    logic               capture_now;
    logic               in_track;
    logic               exit_now;
    logic               data_bad;
    logic               range_bad;
    logic               wait_bad;
    logic               violation;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    // Capture is suppressed in a reset cycle so the tracker never sees a
    // captured pulse that the checker is about to forget.
    assign capture_now = (state_q == IDLE) & start & push & ~rst;
    assign in_track    = (state_q == TRACK) & ~rst;

    // Exit only exists in TRACK; a pop in the capture cycle removes an older
    // entry and must not be mistaken for the magic packet leaving.
    assign exit_now    = in_track & pop & (cnt == '0);

    assign data_bad    = exit_now & (data_out != magic_q);

    // Counts above DEPTH-1 come from decrementing past zero (popping beyond
    // the packet) or from counting more entries than the FIFO can hold.
    assign range_bad   = in_track & (cnt > CNTWID'(DEPTH - 1));

    // The counter holds MAXWAIT on the (MAXWAIT+1)-th TRACK cycle; an exit in
    // that same cycle is still on time.
    assign wait_bad    = in_track & (wait_q == WCW'(MAXWAIT)) & ~exit_now;

    assign violation   = data_bad | range_bad | wait_bad;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture_now) state_d = TRACK;
            TRACK:   if (exit_now)    state_d = DONE;
            DONE:    state_d = DONE;     // terminal until reset
            default: state_d = IDLE;     // unused encoding recovers to IDLE
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // captured is combinational so the tracker excludes the magic packet's own
    // push in the capture cycle.
    always_comb begin
        captured = 1'b0;
        exit     = 1'b0;
        unique case (state_q)
            IDLE:    captured = capture_now;
            TRACK: begin
                captured = 1'b1;
                exit     = exit_now;
            end
            DONE:    captured = 1'b1;
            default: captured = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Magic data latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            magic_q <= '0;
        end else if (capture_now) begin
            magic_q <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Wait counter: zero on TRACK entry, saturating at MAXWAIT
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (capture_now) begin
            wait_q <= '0;
        end else if (in_track && (wait_q != WCW'(MAXWAIT))) begin
            wait_q <= wait_q + WCW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (violation) begin
            err_q <= 1'b1;
        end
    end

    assign state      = state_q;
    assign magic_data = magic_q;
    assign err        = err_q;
    assign prop       = ~err_q;

endmodule
